// File: rtl/lcd_pkg.sv
// Shared sizes and FSM state encoding for the LCD character-buffer arbiter.
package lcd_pkg;
    localparam int NREQ   = 3;
    localparam int DAT_W  = 8;
    localparam int ADDR_W = 5;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_IDLE = 2'd2,
        REPAINT   = 2'd3
    } state_t;
endpackage

// File: rtl/lcd_arbiter_if.sv
// Requester-side bundle between the arbiter and its clients / the LCD driver.
interface lcd_arbiter_if;
    import lcd_pkg::*;

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        done;
    logic [NREQ*DAT_W-1:0]  dat_in;
    logic [NREQ*ADDR_W-1:0] addr_in;
    logic [NREQ-1:0]        we_in;
    logic                   lcd_busy;
    logic [NREQ-1:0]        gnt;
    logic [DAT_W-1:0]       lcd_dat;
    logic [ADDR_W-1:0]      lcd_addr;
    logic                   lcd_we;
    logic                   lcd_repaint;
    logic                   timeout_err;

    modport master (
        output req, done, dat_in, addr_in, we_in, lcd_busy,
        input  gnt, lcd_dat, lcd_addr, lcd_we, lcd_repaint, timeout_err
    );

    modport slave (
        input  req, done, dat_in, addr_in, we_in, lcd_busy,
        output gnt, lcd_dat, lcd_addr, lcd_we, lcd_repaint, timeout_err
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first requesting index strictly after the last
// granted one, wrapping from the top index back to 0.
module rr_pick
    import lcd_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] last,
    output logic [NREQ-1:0] next
);

    logic [IDX_W-1:0] last_idx_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;
    logic             hit_s;

    // Scan the requesters in rotated order starting one past the last grant
    always_comb begin
        last_idx_s = '0;
        idx_s      = '0;
        found_s    = 1'b0;
        hit_s      = 1'b0;
        next       = '0;
        for (int i = 0; i < NREQ; i++) begin
            last_idx_s = last[i] ? IDX_W'(i) : last_idx_s;
        end
        for (int k = 1; k <= NREQ; k++) begin
            idx_s        = IDX_W'((int'(last_idx_s) + k) % NREQ);
            hit_s        = req[idx_s] & ~found_s;
            next[idx_s]  = next[idx_s] | hit_s;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/lcd_arbiter.sv
// Arbitrates three requesters onto the LCD character buffer, one frame at a
// time, with a repaint request after each completed frame and a grant timeout.
module lcd_arbiter
    import lcd_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    lcd_arbiter_if.slave  bus
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 9) ? $clog2(TIMEOUT + 1) : 9;
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [NREQ-1:0]  LAST_RST   = {1'b1, {(NREQ-1){1'b0}}};

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DAT_W-1:0]    dat_q, dat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                repaint_q, repaint_d;
    logic                terr_q, terr_d;
    logic [NREQ-1:0]     pick_s;
    logic [DAT_W-1:0]    dat_sel_s;
    logic [ADDR_W-1:0]   addr_sel_s;

    rr_pick u_rr_pick (
        .req  (bus.req),
        .last (last_q),
        .next (pick_s)
    );

    // Forward only the currently granted requester's data and address
    always_comb begin
        dat_sel_s  = '0;
        addr_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            dat_sel_s  = dat_sel_s  | ({DAT_W{gnt_q[i]}}  & bus.dat_in[i*DAT_W +: DAT_W]);
            addr_sel_s = addr_sel_s | ({ADDR_W{gnt_q[i]}} & bus.addr_in[i*ADDR_W +: ADDR_W]);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = '0;
        repaint_d = 1'b0;
        terr_d    = 1'b0;
        // Masked by the registered grant, so a write is never forwarded
        // unless a grant was already visible in the previous cycle.
        we_d      = |(bus.we_in & gnt_q);
        dat_d     = dat_sel_s;
        addr_d    = addr_sel_s;
        case (state_q)
            IDLE: begin
                if ((bus.req != '0) && !bus.lcd_busy) begin
                    state_d = GRANT;
                    gnt_d   = pick_s;
                    last_d  = pick_s;
                end else begin
                    gnt_d   = '0;
                end
            end
            GRANT: begin
                if ((bus.done & gnt_q) != '0) begin
                    state_d = WAIT_IDLE;
                    gnt_d   = '0;
                end else if ((bus.req & gnt_q) == '0) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (cnt_q == TIMEOUT_M1) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (!bus.lcd_busy) begin
                    state_d   = REPAINT;
                    repaint_d = 1'b1;
                end else begin
                    state_d   = WAIT_IDLE;
                end
            end
            REPAINT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            last_q    <= LAST_RST;
            cnt_q     <= '0;
            dat_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            repaint_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            dat_q     <= dat_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            repaint_q <= repaint_d;
            terr_q    <= terr_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.lcd_dat     = dat_q;
    assign bus.lcd_addr    = addr_q;
    assign bus.lcd_we      = we_q;
    assign bus.lcd_repaint = repaint_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Directed bench for lcd_arbiter (TIMEOUT=8) with hand-computed expectations.
module tb_lcd_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    lcd_arbiter_if bus();

    lcd_arbiter #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] order [4];
        n_checks = 0;
        n_errors = 0;
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

        rst = 1'b1;
        bus.req = '0; bus.done = '0; bus.dat_in = '0; bus.addr_in = '0;
        bus.we_in = '0; bus.lcd_busy = 1'b0;
        tick(); tick();
        check("rst_gnt", bus.gnt, 0);
        check("rst_we", bus.lcd_we, 0);
        check("rst_dat", bus.lcd_dat, 0);
        check("rst_addr", bus.lcd_addr, 0);
        check("rst_repaint", bus.lcd_repaint, 0);
        check("rst_terr", bus.timeout_err, 0);

        // Basic grant and single write from requester 0
        rst = 1'b0;
        bus.req = 3'b001;
        tick();
        check("t1_gnt", bus.gnt, 3'b001);
        bus.we_in = 3'b001; bus.dat_in = 24'h000041; bus.addr_in = 15'd5;
        tick();
        check("t1_we", bus.lcd_we, 1);
        check("t1_dat", bus.lcd_dat, 8'h41);
        check("t1_addr", bus.lcd_addr, 5'd5);
        bus.we_in = '0; bus.done = 3'b001;
        tick();
        check("t1_gnt_clr", bus.gnt, 0);
        check("t1_we_clr", bus.lcd_we, 0);
        bus.done = '0; bus.req = '0;
        tick();
        check("t1_repaint", bus.lcd_repaint, 1);
        tick();
        check("t1_repaint_end", bus.lcd_repaint, 0);

        // Round-robin order from reset with everyone requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 3'b111;
        for (int f = 0; f < 4; f++) begin
            tick();
            check("rr_gnt", bus.gnt, order[f]);
            check("rr_repaint_lo", bus.lcd_repaint, 0);
            bus.done = order[f];
            tick();
            check("rr_gnt_clr", bus.gnt, 0);
            bus.done = '0;
            tick();
            check("rr_repaint", bus.lcd_repaint, 1);
            tick();
            check("rr_repaint_end", bus.lcd_repaint, 0);
        end
        bus.req = '0;

        // Repaint waits for lcd_busy to fall
        bus.req = 3'b010;
        tick();
        check("busy_gnt", bus.gnt, 3'b010);
        bus.done = 3'b010; bus.lcd_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.done = '0; bus.req = '0;
            check("busy_no_repaint", bus.lcd_repaint, 0);
        end
        bus.lcd_busy = 1'b0;
        tick();
        check("busy_repaint", bus.lcd_repaint, 1);
        tick();
        check("busy_repaint_end", bus.lcd_repaint, 0);

        // Timeout of requester 2
        bus.req = 3'b100;
        tick();
        check("to_gnt", bus.gnt, 3'b100);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_hold", bus.gnt, 3'b100);
            check("to_terr_lo", bus.timeout_err, 0);
        end
        tick();
        check("to_gnt_clr", bus.gnt, 0);
        check("to_terr", bus.timeout_err, 1);
        bus.req = '0;
        tick();
        check("to_terr_end", bus.timeout_err, 0);
        check("to_no_repaint", bus.lcd_repaint, 0);
        tick();
        check("to_no_repaint2", bus.lcd_repaint, 0);

        // Non-granted requester's write and done are ignored
        bus.req = 3'b011;
        tick();
        check("ng_gnt", bus.gnt, 3'b001);
        bus.we_in = 3'b010; bus.dat_in = 24'h005500; bus.addr_in = 15'h0120; bus.done = 3'b010;
        tick();
        check("ng_we", bus.lcd_we, 0);
        check("ng_dat", bus.lcd_dat, 0);
        check("ng_gnt_held", bus.gnt, 3'b001);
        bus.we_in = '0; bus.done = '0; bus.dat_in = '0; bus.addr_in = '0;
        tick();
        check("ng_gnt_held2", bus.gnt, 3'b001);

        // Reset in WAIT_IDLE aborts the frame
        bus.done = 3'b001;
        tick();
        check("rw_gnt_clr", bus.gnt, 0);
        bus.done = '0; bus.req = '0; bus.lcd_busy = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rw_gnt", bus.gnt, 0);
        check("rw_we", bus.lcd_we, 0);
        check("rw_repaint", bus.lcd_repaint, 0);
        check("rw_terr", bus.timeout_err, 0);
        rst = 1'b0; bus.lcd_busy = 1'b0;
        tick();
        check("rw_no_repaint", bus.lcd_repaint, 0);
        tick();
        check("rw_no_repaint2", bus.lcd_repaint, 0);

        // lcd_busy blocks a grant in IDLE
        bus.lcd_busy = 1'b1; bus.req = 3'b001;
        tick();
        check("blk_gnt", bus.gnt, 0);
        bus.lcd_busy = 1'b0;
        tick();
        check("blk_gnt_go", bus.gnt, 3'b001);

        // done in the same cycle the timeout would fire: done wins
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check("dt_hold", bus.gnt, 3'b001);
        bus.done = 3'b001;
        tick();
        check("dt_gnt_clr", bus.gnt, 0);
        check("dt_terr", bus.timeout_err, 0);
        bus.done = '0; bus.req = '0;
        tick();
        check("dt_repaint", bus.lcd_repaint, 1);
        tick();

        // Granted requester drops req without done
        bus.req = 3'b010;
        tick();
        check("drop_gnt", bus.gnt, 3'b010);
        bus.req = '0;
        tick();
        check("drop_gnt_clr", bus.gnt, 0);
        tick();
        check("drop_no_repaint", bus.lcd_repaint, 0);
        tick();
        check("drop_no_repaint2", bus.lcd_repaint, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_arbiter.md
LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles a grant is held without done before the arbiter revokes it.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  3  per-requester access request; bit i is requester i.
REQ-005 done  input  3  per-requester frame-complete strobe, one cycle.
REQ-006 dat_in  input  24  character data; requester i on bits [8i+7:8i].
REQ-007 addr_in  input  15  character address 0..31; requester i on bits [5i+4:5i].
REQ-008 we_in  input  3  per-requester write strobe.
REQ-009 lcd_busy  input  1  LCD driver busy flag.
REQ-010 gnt  output  3  one-hot grant, or all-zero.
REQ-011 lcd_dat  output  8  data to LCD character buffer.
REQ-012 lcd_addr  output  5  address to LCD character buffer.
REQ-013 lcd_we  output  1  write strobe to LCD character buffer.
REQ-014 lcd_repaint  output  1  one-cycle repaint request to LCD driver.
REQ-015 timeout_err  output  1  one-cycle pulse on grant revocation by timeout.

Function
REQ-016 The FSM SHALL have four states: IDLE, GRANT, WAIT_IDLE, REPAINT.
REQ-017 In IDLE with req!=0 and lcd_busy=0, the FSM SHALL select the first requesting index after the last granted index (round-robin, wrap 2->0), assert gnt one cycle later, and enter GRANT.
REQ-018 In IDLE, lcd_busy=1 SHALL block any grant.
REQ-019 A requester SHALL NOT be granted twice in a row while another requester's req is pending.
REQ-020 In GRANT, lcd_dat/lcd_addr/lcd_we SHALL be the granted requester's inputs, registered (one-cycle latency); inputs of non-granted requesters SHALL be ignored.
REQ-021 lcd_we SHALL be 0 whenever gnt was 0 in the preceding cycle.
REQ-022 Writes in GRANT SHALL pass regardless of lcd_busy.
REQ-023 done from the granted requester SHALL clear gnt next cycle and enter WAIT_IDLE; a we_in in the same cycle as done SHALL still be forwarded.
REQ-024 done from a non-granted requester SHALL be ignored.
REQ-025 The granted requester deasserting req without done SHALL clear gnt next cycle and return to IDLE with no repaint.
REQ-026 A 9-bit-minimum counter SHALL count cycles in GRANT; on reaching TIMEOUT without done, gnt SHALL clear, timeout_err SHALL pulse once, and the FSM SHALL return to IDLE with no repaint.
REQ-027 If done and timeout occur in the same cycle, done SHALL win: no timeout_err, normal WAIT_IDLE path.
REQ-028 WAIT_IDLE SHALL hold until lcd_busy=0, then enter REPAINT.
REQ-029 REPAINT SHALL assert lcd_repaint for exactly one cycle, then return to IDLE.
REQ-030 The last-granted pointer SHALL update only on entry to GRANT.

Reset
REQ-031 On rst=1 at a clock edge: gnt=0, lcd_dat=0, lcd_addr=0, lcd_we=0, lcd_repaint=0, timeout_err=0, state=IDLE, counter=0, last-granted=2 so requester 0 wins first.
REQ-032 rst mid-GRANT or mid-WAIT_IDLE SHALL abort the frame with no repaint and no timeout_err.

Structure
REQ-033 State encodings, NREQ=3, DAT_W=8, ADDR_W=5 SHALL reside in shared include lcd_pkg.
REQ-034 Round-robin selection SHALL be one combinational sub-module, rr_pick (inputs req, last; output one-hot next).

Verification
REQ-035 Reset, then req=3'b001, lcd_busy=0 -> gnt=3'b001 one cycle later; we_in[0]=1, dat=0x41, addr=5 -> lcd_we=1, lcd_dat=0x41, lcd_addr=5 next cycle.
REQ-036 req=3'b111 held, each grant ending with done -> grant order 0,1,2,0; one lcd_repaint per frame.
REQ-037 Granted 1, done[1] with lcd_busy=1 for 10 cycles -> lcd_repaint pulses in the first cycle after lcd_busy falls, not before.
REQ-038 TIMEOUT=8, requester 2 granted, no done -> gnt=0 and timeout_err=1 after 8 cycles in GRANT; no lcd_repaint.
REQ-039 we_in[1]=1 while gnt=3'b001 -> lcd_we stays 0; done[1] ignored.
REQ-040 rst asserted in WAIT_IDLE -> all outputs 0 next cycle; no lcd_repaint afterwards.
